// File: rtl/addr_region_checker_if.sv
// addr_region_checker_if: request/response handshake bundle between a requester and addr_region_checker
interface addr_region_checker_if #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic [1:0]        req_size;
  logic [1:0]        req_kind;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_hit;
  logic [RIDX_W-1:0] resp_region;
  logic              resp_misaligned;
  logic              resp_fault;
  modport master (
    output req_valid, req_addr, req_size, req_kind, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_region, resp_misaligned, resp_fault
  );
  modport slave (
    input  req_valid, req_addr, req_size, req_kind, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_region, resp_misaligned, resp_fault
  );
endinterface

// File: rtl/addr_region_checker.sv
// addr_region_checker: NREGION programmable range/permission/alignment checker with registered response.
// Defining ADDR_CHECK_STATS_EN adds a saturating consumed-fault counter with stats_clear.
module addr_region_checker #(
  parameter int XLEN    = 32,
  parameter int NREGION = 4,
  parameter int RIDX_W  = (NREGION > 1) ? $clog2(NREGION) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [RIDX_W-1:0] cfg_idx,
  input  logic [XLEN-1:0]   cfg_base,
  input  logic [XLEN-1:0]   cfg_limit,
  input  logic [3:0]        cfg_attr,
`ifdef ADDR_CHECK_STATS_EN
  input  logic              stats_clear,
  output logic [31:0]       fault_count,
`endif
  addr_region_checker_if.slave bus
);
  logic [XLEN-1:0]   base_q [NREGION];
  logic [XLEN-1:0]   base_d [NREGION];
  logic [XLEN-1:0]   limit_q [NREGION];
  logic [XLEN-1:0]   limit_d [NREGION];
  logic [3:0]        attr_q [NREGION];
  logic [3:0]        attr_d [NREGION];
  logic              resp_valid_q, resp_valid_d;
  logic              hit_q, hit_d;
  logic              mis_q, mis_d;
  logic              fault_q, fault_d;
  logic [RIDX_W-1:0] region_q, region_d;
  logic              accept, wrap, hit, mis, denied, illegal;
  logic [RIDX_W-1:0] ridx;
  logic [3:0]        span, attr;
  logic [XLEN:0]     last;

  assign bus.req_ready       = !resp_valid_q || bus.resp_ready;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_hit        = hit_q;
  assign bus.resp_region     = region_q;
  assign bus.resp_misaligned = mis_q;
  assign bus.resp_fault      = fault_q;

  always_comb begin
    span = 4'((5'd1 << bus.req_size) - 5'd1);
    last = {1'b0, bus.req_addr} + {{(XLEN-3){1'b0}}, span};
    wrap = last[XLEN];
    mis  = |(bus.req_addr[3:0] & span);
    hit  = 1'b0;
    ridx = '0;
    // descending scan so the lowest matching index is the one left standing
    for (int i = NREGION - 1; i >= 0; i--)
      if (attr_q[i][3] && base_q[i] <= bus.req_addr && last[XLEN-1:0] <= limit_q[i] && !wrap) begin
        hit  = 1'b1;
        ridx = RIDX_W'(i);
      end
    attr    = attr_q[ridx];
    denied  = bus.req_kind == 2'd3 || !attr[bus.req_kind];
    illegal = bus.req_size == 2'd3 && XLEN != 64;
    accept       = bus.req_valid && bus.req_ready;
    resp_valid_d = accept || (resp_valid_q && !bus.resp_ready);
    hit_d    = accept ? hit : hit_q;
    region_d = accept ? ridx : region_q;
    mis_d    = accept ? mis : mis_q;
    fault_d  = accept ? (!hit || mis || denied || wrap || illegal) : fault_q;
    base_d  = base_q;
    limit_d = limit_q;
    attr_d  = attr_q;
    if (cfg_valid && int'(cfg_idx) < NREGION) begin
      base_d[cfg_idx]  = cfg_base;
      limit_d[cfg_idx] = cfg_limit;
      attr_d[cfg_idx]  = cfg_attr;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NREGION; i++) begin
        base_q[i]  <= '0;
        limit_q[i] <= '0;
        attr_q[i]  <= '0;
      end
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      region_q     <= '0;
      mis_q        <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      base_q       <= base_d;
      limit_q      <= limit_d;
      attr_q       <= attr_d;
      resp_valid_q <= resp_valid_d;
      hit_q        <= hit_d;
      region_q     <= region_d;
      mis_q        <= mis_d;
      fault_q      <= fault_d;
    end

`ifdef ADDR_CHECK_STATS_EN
  logic [31:0] fault_count_q, fault_count_d;

  always_comb
    fault_count_d = stats_clear ? '0 :
                    (resp_valid_q && bus.resp_ready && fault_q && !(&fault_count_q)) ? fault_count_q + 32'd1 :
                    fault_count_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) fault_count_q <= '0;
    else fault_count_q <= fault_count_d;

  assign fault_count = fault_count_q;
`endif
endmodule

// File: tb/tb_addr_region_checker.sv
// tb_addr_region_checker: directed + randomized checks of addr_region_checker against a behavioural model
module tb_addr_region_checker;
  localparam int XLEN = 32, NREGION = 3, RIDX_W = 2;

  typedef struct packed {
    logic              hit;
    logic [RIDX_W-1:0] region;
    logic              mis;
    logic              fault;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_valid = 1'b0;
  logic [RIDX_W-1:0] cfg_idx = '0;
  logic [31:0] cfg_base = '0, cfg_limit = '0;
  logic [3:0] cfg_attr = '0;
`ifdef ADDR_CHECK_STATS_EN
  logic stats_clear = 1'b0;
  logic [31:0] fault_count;
`endif
  int checks = 0, errors = 0;
  logic [31:0] m_base [NREGION];
  logic [31:0] m_limit [NREGION];
  logic [3:0]  m_attr [NREGION];
  res_t e, e2;

  addr_region_checker_if #(.XLEN(XLEN), .RIDX_W(RIDX_W)) bus ();

  addr_region_checker #(.XLEN(XLEN), .NREGION(NREGION), .RIDX_W(RIDX_W)) dut (
    .clk(clk),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_idx(cfg_idx),
    .cfg_base(cfg_base),
    .cfg_limit(cfg_limit),
    .cfg_attr(cfg_attr),
`ifdef ADDR_CHECK_STATS_EN
    .stats_clear(stats_clear),
    .fault_count(fault_count),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] a, input logic [1:0] s, input logic [1:0] k);
    res_t r;
    longint unsigned nbytes, first, last;
    logic ok;
    r = '0;
    nbytes = 64'd1 << s;
    first = 64'(a);
    last = first + nbytes - 1;
    r.mis = (first % nbytes) != 0;
    for (int i = 0; i < NREGION; i++)
      if (!r.hit && m_attr[i][3] && 64'(m_base[i]) <= first && last <= 64'(m_limit[i])) begin
        r.hit = 1'b1;
        r.region = RIDX_W'(i);
      end
    case (k)
      2'd0: ok = m_attr[r.region][0];
      2'd1: ok = m_attr[r.region][1];
      2'd2: ok = m_attr[r.region][2];
      default: ok = 1'b0;
    endcase
    r.fault = !r.hit || r.mis || !ok || last > 64'hFFFF_FFFF || s == 2'd3;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input res_t x);
    chk({tag, " valid"}, 64'(bus.resp_valid), 64'd1);
    chk({tag, " hit"}, 64'(bus.resp_hit), 64'(x.hit));
    chk({tag, " region"}, 64'(bus.resp_region), 64'(x.region));
    chk({tag, " mis"}, 64'(bus.resp_misaligned), 64'(x.mis));
    chk({tag, " fault"}, 64'(bus.resp_fault), 64'(x.fault));
  endtask

  task automatic m_reset();
    for (int i = 0; i < NREGION; i++) begin
      m_base[i] = '0;
      m_limit[i] = '0;
      m_attr[i] = '0;
    end
  endtask

  task automatic wr_cfg(input int idx, input logic [31:0] b, input logic [31:0] l, input logic [3:0] a);
    cfg_valid = 1'b1;
    cfg_idx = RIDX_W'(idx);
    cfg_base = b;
    cfg_limit = l;
    cfg_attr = a;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    if (idx < NREGION) begin
      m_base[idx] = b;
      m_limit[idx] = l;
      m_attr[idx] = a;
    end
  endtask

  task automatic do_req(input string tag, input logic [31:0] a, input logic [1:0] s, input logic [1:0] k, output res_t x);
    x = model(a, s, k);
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    bus.req_size = s;
    bus.req_kind = k;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk_resp(tag, x);
  endtask

  task automatic stall(input string tag, input int n, input res_t x);
    bus.resp_ready = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1 chk({tag, " req_ready"}, 64'(bus.req_ready), 64'd0);
      chk_resp(tag, x);
    end
    bus.resp_ready = 1'b1;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_size = '0;
    bus.req_kind = '0;
    bus.resp_ready = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 64'(bus.resp_valid), 64'd0);
    chk("rst hit", 64'(bus.resp_hit), 64'd0);
    chk("rst region", 64'(bus.resp_region), 64'd0);
    chk("rst mis", 64'(bus.resp_misaligned), 64'd0);
    chk("rst fault", 64'(bus.resp_fault), 64'd0);
    reset = 1'b0;
    #1 chk("rst req_ready", 64'(bus.req_ready), 64'd1);
`ifdef ADDR_CHECK_STATS_EN
    chk("rst count", 64'(fault_count), 64'd0);
`endif
    do_req("noconf", 32'h0000_1000, 2'd2, 2'd0, e);

    wr_cfg(0, 32'h8000_0000, 32'h8000_FFFF, 4'b1101);
    do_req("r0 top word", 32'h8000_FFFC, 2'd2, 2'd0, e);
    do_req("r0 misal", 32'h8000_FFFE, 2'd2, 2'd0, e);
    do_req("r0 last byte", 32'h8000_FFFF, 2'd0, 2'd0, e);
    do_req("r0 write", 32'h8000_0000, 2'd2, 2'd1, e);
    do_req("r0 exec", 32'h8000_0100, 2'd1, 2'd2, e);
    do_req("r0 kind3", 32'h8000_0100, 2'd0, 2'd3, e);
    do_req("r0 dword", 32'h8000_0100, 2'd3, 2'd0, e);

    wr_cfg(1, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1001);
    do_req("prio", 32'h8000_0010, 2'd2, 2'd0, e);
    do_req("r1", 32'h0000_1000, 2'd2, 2'd0, e);
    do_req("wrap", 32'hFFFF_FFFE, 2'd2, 2'd0, e);
    do_req("edge end", 32'hFFFF_FFFC, 2'd2, 2'd0, e);
    wr_cfg(3, 32'h0, 32'hFFFF_FFFF, 4'b1111);
    do_req("idx oob", 32'h0000_1000, 2'd2, 2'd1, e);
    wr_cfg(2, 32'h2000, 32'h1000, 4'b1111);
    do_req("inverted", 32'h0000_1800, 2'd0, 2'd1, e);

    do_req("bp first", 32'h8000_0010, 2'd2, 2'd0, e);
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h0000_1000;
    bus.req_size = 2'd2;
    bus.req_kind = 2'd1;
    e2 = model(32'h0000_1000, 2'd2, 2'd1);
    stall("bp hold", 3, e);
    @(posedge clk);
    #1 chk_resp("bp b2b 1", e2);
    e = model(32'h8000_FFFF, 2'd0, 2'd2);
    bus.req_addr = 32'h8000_FFFF;
    bus.req_size = 2'd0;
    bus.req_kind = 2'd2;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk_resp("bp b2b 2", e);

    e = model(32'h8000_0000, 2'd2, 2'd0);
    cfg_valid = 1'b1;
    cfg_idx = 2'd0;
    cfg_base = 32'h8000_0000;
    cfg_limit = 32'h8000_FFFF;
    cfg_attr = 4'b0000;
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h8000_0000;
    bus.req_size = 2'd2;
    bus.req_kind = 2'd0;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    bus.req_valid = 1'b0;
    m_attr[0] = 4'b0000;
    chk_resp("collide old", e);
    do_req("collide new", 32'h8000_0000, 2'd2, 2'd0, e);

`ifdef ADDR_CHECK_STATS_EN
    stats_clear = 1'b1;
    @(posedge clk);
    #1 stats_clear = 1'b0;
    chk("count clear", 64'(fault_count), 64'd0);
    for (int i = 0; i < 5; i++) do_req("stat fault", 32'h0000_0003, 2'd2, 2'd0, e);
    @(posedge clk);
    #1 chk("count 5", 64'(fault_count), 64'd5);
    do_req("stat fault", 32'h0000_0001, 2'd1, 2'd0, e);
    stats_clear = 1'b1;
    @(posedge clk);
    #1 stats_clear = 1'b0;
    chk("count clear wins", 64'(fault_count), 64'd0);
`endif

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        logic [31:0] b;
        b = 32'h4000_0000 + $urandom_range(0, 4095);
        wr_cfg($urandom_range(0, 3), b, b + $urandom_range(0, 2048) - 32'd64, 4'($urandom_range(0, 15)));
      end
      do_req("rand",
             ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : 32'h4000_0000 + $urandom_range(0, 6000),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), e);
      if ($urandom_range(0, 3) == 0) stall("rand stall", $urandom_range(1, 3), e);
    end

    do_req("pre reset", 32'h0000_0003, 2'd2, 2'd0, e);
    bus.resp_ready = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("async rst valid", 64'(bus.resp_valid), 64'd0);
    chk("async rst req_ready", 64'(bus.req_ready), 64'd1);
`ifdef ADDR_CHECK_STATS_EN
    chk("async rst count", 64'(fault_count), 64'd0);
`endif
    m_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    do_req("post reset", 32'h0000_1000, 2'd2, 2'd0, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
